// File: rtl/decode_if.sv
// Handshake and operand bus between the fetch side, the decode stage and the ALU.
// The decode stage uses the slave view; the producer/consumer pair uses the master view.
interface decode_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       instr;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] rs;
  logic [DATA_W-1:0] rt;
  logic [DATA_W-1:0] imm;
  logic [11:0]       cnt;
  logic [4:0]        rd;
  logic              reg_write;
  logic              illegal;

  modport master (
    output in_valid, instr, out_ready,
    input  in_ready, out_valid, rs, rt, imm, cnt, rd, reg_write, illegal
  );

  modport slave (
    input  in_valid, instr, out_ready,
    output in_ready, out_valid, rs, rt, imm, cnt, rd, reg_write, illegal
  );
endinterface

// File: rtl/decode_stage.sv
// Instruction decode stage: 32x32 register file with write-through bypass,
// MIPS-style field decode and a one-entry EMPTY/FULL output buffer.
module decode_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_en,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  decode_if.slave           bus
);

  typedef enum logic {EMPTY, FULL} state_t;

  function automatic logic signed [DATA_W-1:0] sext16(input logic signed [15:0] v);
    return DATA_W'(v);
  endfunction

  function automatic logic signed [DATA_W-1:0] zext16(input logic [15:0] v);
    return DATA_W'(v);
  endfunction

  logic [DATA_W-1:0] regs [32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_en && (wb_addr != 5'd0)) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // ---- p0: field decode and operand read (combinational) ----
  logic [5:0]               op_p0, fn_p0;
  logic [4:0]               rsa_p0, rta_p0;
  logic [DATA_W-1:0]        rs_p0, rt_p0;
  logic signed [DATA_W-1:0] imm_p0;
  logic [11:0]              cnt_p0;
  logic [4:0]               rd_p0;
  logic                     rw_p0, ill_p0;

  assign op_p0  = bus.instr[31:26];
  assign fn_p0  = bus.instr[5:0];
  assign rsa_p0 = bus.instr[25:21];
  assign rta_p0 = bus.instr[20:16];

  always_comb begin
    rs_p0 = (rsa_p0 == 5'd0) ? '0 :
            (wb_en && wb_addr == rsa_p0) ? wb_data : regs[rsa_p0];
    rt_p0 = (rta_p0 == 5'd0) ? '0 :
            (wb_en && wb_addr == rta_p0) ? wb_data : regs[rta_p0];
    cnt_p0 = '0;
    imm_p0 = '0;
    rd_p0  = '0;
    rw_p0  = 1'b0;
    ill_p0 = 1'b0;
    case (op_p0)
      6'd0: begin
        if (fn_p0 inside {6'd32, 6'd34, 6'd24, 6'd26, 6'd36, 6'd37}) begin
          cnt_p0 = {6'b0, fn_p0};
          rd_p0  = bus.instr[15:11];
          rw_p0  = 1'b1;
        end else begin
          ill_p0 = 1'b1;
        end
      end
      6'd8, 6'd32, 6'd40: begin
        cnt_p0 = {op_p0, 6'b0};
        rd_p0  = bus.instr[20:16];
        rw_p0  = (op_p0 != 6'd40);
        imm_p0 = sext16(bus.instr[15:0]);
      end
      6'd12, 6'd13: begin
        cnt_p0 = {op_p0, 6'b0};
        rd_p0  = bus.instr[20:16];
        rw_p0  = 1'b1;
        imm_p0 = zext16(bus.instr[15:0]);
      end
      default: ill_p0 = 1'b1;
    endcase
    if (rd_p0 == 5'd0) rw_p0 = 1'b0;
  end

  // ---- p1: output buffer ----
  state_t            state_p1;
  logic              vld_p1, accept_p0;
  logic [DATA_W-1:0] rs_p1, rt_p1, imm_p1;
  logic [11:0]       cnt_p1;
  logic [4:0]        rd_p1;
  logic              rw_p1, ill_p1;

  assign vld_p1       = (state_p1 == FULL);
  assign bus.in_ready = !vld_p1 || bus.out_ready;
  assign accept_p0    = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p1 <= EMPTY;
      rs_p1    <= '0;
      rt_p1    <= '0;
      imm_p1   <= '0;
      cnt_p1   <= '0;
      rd_p1    <= '0;
      rw_p1    <= 1'b0;
      ill_p1   <= 1'b0;
    end else begin
      if (accept_p0) begin
        state_p1 <= FULL;
        rs_p1    <= rs_p0;
        rt_p1    <= rt_p0;
        imm_p1   <= imm_p0;
        cnt_p1   <= cnt_p0;
        rd_p1    <= rd_p0;
        rw_p1    <= rw_p0;
        ill_p1   <= ill_p0;
      end else if (state_p1 == FULL && bus.out_ready) begin
        state_p1 <= EMPTY;
      end
    end
  end

  assign bus.out_valid = vld_p1;
  assign bus.rs        = rs_p1;
  assign bus.rt        = rt_p1;
  assign bus.imm       = imm_p1;
  assign bus.cnt       = cnt_p1;
  assign bus.rd        = rd_p1;
  assign bus.reg_write = rw_p1;
  assign bus.illegal   = ill_p1;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: register writes, decode of each instruction class,
// stall/hold, bypass, register 0, rd=0 and mid-operation reset.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  int          n_cmp = 0;
  int          n_err = 0;

  decode_if #(.DATA_W(32)) bus ();

  decode_stage #(.DATA_W(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .wb_data (wb_data),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic vld, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [31:0] imm,
                         input logic [11:0] cnt, input logic [4:0] rd,
                         input logic rw, input logic ill);
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(vld));
    chk({tag, ".rs"},        bus.rs,             rs);
    chk({tag, ".rt"},        bus.rt,             rt);
    chk({tag, ".imm"},       bus.imm,            imm);
    chk({tag, ".cnt"},       32'(bus.cnt),       32'(cnt));
    chk({tag, ".rd"},        32'(bus.rd),        32'(rd));
    chk({tag, ".reg_write"}, 32'(bus.reg_write), 32'(rw));
    chk({tag, ".illegal"},   32'(bus.illegal),   32'(ill));
  endtask

  initial begin
    rst_n         = 1'b0;
    wb_en         = 1'b0;
    wb_addr       = '0;
    wb_data       = '0;
    bus.in_valid  = 1'b0;
    bus.instr     = '0;
    bus.out_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk_out("reset", 1'b0, 32'd0, 32'd0, 32'd0, 12'd0, 5'd0, 1'b0, 1'b0);
    chk("reset.in_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;

    // Load r1=120, r2=145.
    wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'd120;
    @(negedge clk);
    wb_addr = 5'd2; wb_data = 32'd145;
    @(negedge clk);
    wb_en = 1'b0;

    bus.in_valid = 1'b1; bus.instr = 32'h0022_1820;
    @(negedge clk);
    chk_out("add", 1'b1, 32'd120, 32'd145, 32'd0, 12'd32, 5'd3, 1'b1, 1'b0);

    bus.instr = 32'h2025_FFFC;
    @(negedge clk);
    chk_out("addi", 1'b1, 32'd120, 32'd0, 32'hFFFF_FFFC, 12'd512, 5'd5, 1'b1, 1'b0);

    bus.instr = 32'h3406_8000;
    @(negedge clk);
    chk_out("ori", 1'b1, 32'd0, 32'd0, 32'h0000_8000, 12'd832, 5'd6, 1'b1, 1'b0);

    bus.instr = 32'h0022_1821;
    @(negedge clk);
    chk_out("illegal", 1'b1, 32'd120, 32'd145, 32'd0, 12'd0, 5'd0, 1'b0, 1'b1);

    // Stall three cycles with a new instruction pending.
    bus.out_ready = 1'b0; bus.instr = 32'h0022_1820;
    #1 chk("stall.in_ready0", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall.in_ready", 32'(bus.in_ready), 32'd0);
      chk_out("stall.hold", 1'b1, 32'd120, 32'd145, 32'd0, 12'd0, 5'd0, 1'b0, 1'b1);
    end
    bus.out_ready = 1'b1;
    #1 chk("release.in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk_out("release.new", 1'b1, 32'd120, 32'd145, 32'd0, 12'd32, 5'd3, 1'b1, 1'b0);
    @(negedge clk);
    chk("drain.out_valid", 32'(bus.out_valid), 32'd0);

    // Write-through bypass on rs in the accept cycle.
    bus.in_valid = 1'b1; bus.instr = 32'h0022_1820;
    wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'd7;
    @(negedge clk);
    wb_en = 1'b0; bus.in_valid = 1'b0;
    chk_out("bypass", 1'b1, 32'd7, 32'd145, 32'd0, 12'd32, 5'd3, 1'b1, 1'b0);

    // Write to r0 in the accept cycle must neither land nor bypass.
    bus.in_valid = 1'b1; bus.instr = 32'h3406_8000;
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hDEAD_BEEF;
    @(negedge clk);
    wb_en = 1'b0; bus.in_valid = 1'b0;
    chk_out("r0", 1'b1, 32'd0, 32'd0, 32'h0000_8000, 12'd832, 5'd6, 1'b1, 1'b0);

    // R-type with rd=0 never writes back.
    bus.in_valid = 1'b1; bus.instr = 32'h0022_0020;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk_out("rd0", 1'b1, 32'd7, 32'd145, 32'd0, 12'd32, 5'd0, 1'b0, 1'b0);

    // Reset while FULL, with a write attempted during reset.
    rst_n = 1'b0; wb_en = 1'b1; wb_addr = 5'd2; wb_data = 32'd99;
    #1 chk_out("midreset", 1'b0, 32'd0, 32'd0, 32'd0, 12'd0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1; wb_en = 1'b0;
    bus.in_valid = 1'b1; bus.instr = 32'h0022_1820;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk_out("postreset", 1'b1, 32'd0, 32'd0, 32'd0, 12'd32, 5'd3, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: rst_n  input  1  asynchronous active-low reset; asserts immediately, releases synchronously to clk.
REQ-003 SHALL: in_valid  input  1  instr holds an instruction to decode.
REQ-004 SHALL: in_ready  output  1  stage accepts instr this cycle.
REQ-005 SHALL: instr  input  32  MIPS-style instruction word: opcode [31:26], rs [25:21], rt [20:16], rd [15:11], funct [5:0], imm16 [15:0].
REQ-006 SHALL: wb_en, wb_addr, wb_data  input  1/5/32  register-file write port.
REQ-007 SHALL: out_valid  output  1  decoded operands valid toward the ALU.
REQ-008 SHALL: out_ready  input  1  downstream consumes the current output.
REQ-009 SHALL: rs, rt, imm  output  32 each  ALU operands: register values and extended immediate.
REQ-010 SHALL: cnt  output  12  ALU control code.
REQ-011 SHALL: rd  output  5  destination register number.
REQ-012 SHALL: reg_write  output  1  destination is written at writeback.
REQ-013 SHALL: illegal  output  1  decoded instruction is unsupported.

Function
REQ-014 SHALL: contain a 32x32 register file; register 0 reads as 0 and ignores writes.
REQ-015 SHALL: perform a write on a rising edge when wb_en=1 and wb_addr!=0.
REQ-016 SHALL: output buffer is a 2-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-017 SHALL: drive in_ready = !out_valid || out_ready, combinationally.
REQ-018 SHALL: capture on accept (in_valid && in_ready); all outputs are registered, with 1-cycle latency.
REQ-019 SHALL: transition EMPTY->FULL on accept; FULL->EMPTY on out_ready with no accept; FULL->FULL on simultaneous consume and accept, loading new data.
REQ-020 SHALL: hold all outputs stable while out_valid=1 and out_ready=0.
REQ-021 SHALL: write-through bypass: if wb_en=1, wb_addr!=0 and wb_addr matches the rs or rt field in the accept cycle, the captured operand equals wb_data.
REQ-022 SHALL: for opcode 0 with funct in {32,34,24,26,36,37}, set cnt={6'b0,funct}, rd=instr[15:11], reg_write=1.
REQ-023 SHALL: for opcode in {8,12,13,32,40}, set cnt={opcode,6'b0}, rd=instr[20:16].
REQ-024 SHALL: set reg_write=1 for opcodes 8, 12, 13, 32 and reg_write=0 for opcode 40.
REQ-025 SHALL: sign-extend imm16 for opcodes 8, 32, 40; zero-extend for opcodes 12, 13; set imm=0 for R-type.
REQ-026 SHALL: for any other opcode/funct, set cnt=0, imm=0, reg_write=0, illegal=1, with the operands still read.
REQ-027 SHALL: force reg_write=0 when rd=0.
REQ-028 SHALL: leave out_valid, and therefore ALU consumption, untouched by an illegal instruction; flagging only.

Reset
REQ-029 SHALL: on rst_n=0, clear the FSM to EMPTY and all register-file entries to 0.
REQ-030 SHALL: on rst_n=0, reset out_valid=0, rs=rt=imm=0, cnt=0, rd=0, reg_write=0, illegal=0.
REQ-031 SHALL: discard any in-flight output when reset is asserted mid-operation; no write occurs during reset.

Verification
REQ-032 SHALL: write r1=120 and r2=145, then accept 0x00221820 -> next cycle out_valid=1, rs=120, rt=145, cnt=32, rd=3, reg_write=1.
REQ-033 SHALL: with r1=120, accept 0x2025FFFC -> imm=0xFFFFFFFC, cnt=512, rd=5, reg_write=1.
REQ-034 SHALL: accept 0x34068000 -> imm=0x00008000, cnt=832, rs=0, rd=6.
REQ-035 SHALL: accept 0x00221821 -> cnt=0, illegal=1, reg_write=0, out_valid=1.
REQ-036 SHALL: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs stable; then out_ready=1 for 1 cycle -> simultaneous consume and accept, with the new instruction on the outputs.
REQ-037 SHALL: apply wb_en=1, wb_addr=1, wb_data=7 in the same cycle as accepting 0x00221820 -> rs=7.
